// File: rtl/exp_ker_rd_arbiter.sv
// Read-port arbiter for the expand kernel RAM, shared by the 1x1 and 3x3 kernel read controllers.
// Build macro EXP_ARB_FIXED_PRIO_EN selects fixed priority to 3x3; the default build is round-robin.
module exp_ker_rd_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int RAM_LAT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              exp1_req_i,
    input  logic [ADDR_W-1:0] exp1_addr_i,
    output logic              exp1_gnt_o,
    output logic              exp1_rd_vld_o,
    input  logic              exp3_req_i,
    input  logic [ADDR_W-1:0] exp3_addr_i,
    output logic              exp3_gnt_o,
    output logic              exp3_rd_vld_o,
    output logic              ram_rd_en_o,
    output logic [ADDR_W-1:0] ram_rd_addr_o,
    input  logic [DATA_W-1:0] ram_rd_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o
);

    localparam int               CNT_W    = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [1:0]       TAG_NONE = 2'b00;
    localparam logic [1:0]       TAG_EXP1 = 2'b01;
    localparam logic [1:0]       TAG_EXP3 = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT3 = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic [CNT_W-1:0]  beat_cnt_nxt_s;
    logic              owner_req_s;
    logic [ADDR_W-1:0] owner_addr_s;
    logic [1:0]        owner_tag_s;
    logic              burst_end_s;
    logic              inflight_s;
    // Owner tag per return stage; stage RAM_LAT lines up with ram_rd_data_i.
    logic [1:0]        tag_r [RAM_LAT+1];
`ifndef EXP_ARB_FIXED_PRIO_EN
    logic              last3_r;
`endif

    // Decode the current owner's request, address and return tag from the grant state.
    always_comb begin
        owner_req_s  = 1'b0;
        owner_addr_s = {ADDR_W{1'b0}};
        owner_tag_s  = TAG_NONE;
        case (state_r)
            GNT1: begin
                owner_req_s  = exp1_req_i;
                owner_addr_s = exp1_addr_i;
                owner_tag_s  = TAG_EXP1;
            end
            GNT3: begin
                owner_req_s  = exp3_req_i;
                owner_addr_s = exp3_addr_i;
                owner_tag_s  = TAG_EXP3;
            end
            default: begin
                owner_req_s  = 1'b0;
                owner_addr_s = {ADDR_W{1'b0}};
                owner_tag_s  = TAG_NONE;
            end
        endcase
    end

    // A burst closes on its last beat or when the owner lets go of its request.
    assign burst_end_s = (state_r != IDLE) && (!owner_req_s || (beat_cnt_r == CNT_LAST));

    // Grant selection: in IDLE and at every burst end.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
`ifdef EXP_ARB_FIXED_PRIO_EN
                if (exp3_req_i) begin
                    state_nxt_s = GNT3;
                end else if (exp1_req_i) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
`else
                if (exp1_req_i && exp3_req_i) begin
                    state_nxt_s = last3_r ? GNT1 : GNT3;
                end else if (exp3_req_i) begin
                    state_nxt_s = GNT3;
                end else if (exp1_req_i) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
`endif
            end
            GNT1: begin
                if (!burst_end_s) begin
                    state_nxt_s = GNT1;
                end else if (exp3_req_i) begin
                    state_nxt_s = GNT3;
                end else if (exp1_req_i) begin
                    state_nxt_s = GNT1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GNT3: begin
                if (!burst_end_s) begin
                    state_nxt_s = GNT3;
`ifdef EXP_ARB_FIXED_PRIO_EN
                end else if (exp3_req_i) begin
                    state_nxt_s = GNT3;
                end else if (exp1_req_i) begin
                    state_nxt_s = GNT1;
`else
                end else if (exp1_req_i) begin
                    state_nxt_s = GNT1;
                end else if (exp3_req_i) begin
                    state_nxt_s = GNT3;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Beat counter restarts at every burst boundary.
    always_comb begin
        if (burst_end_s) begin
            beat_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (owner_req_s) begin
            beat_cnt_nxt_s = beat_cnt_r + CNT_ONE;
        end else begin
            beat_cnt_nxt_s = beat_cnt_r;
        end
    end

    // A read stays in flight until its strobe cycle has been produced.
    always_comb begin
        inflight_s = owner_req_s;
        for (int k = 0; k <= RAM_LAT; k++) begin
            inflight_s = inflight_s | (tag_r[k] != TAG_NONE);
        end
    end

    // State, counter, issue registers and the owner-tagged read-return pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            state_r       <= IDLE;
            beat_cnt_r    <= {CNT_W{1'b0}};
`ifndef EXP_ARB_FIXED_PRIO_EN
            last3_r       <= 1'b0;
`endif
            for (int k = 0; k <= RAM_LAT; k++) begin
                tag_r[k] <= TAG_NONE;
            end
            exp1_gnt_o    <= 1'b0;
            exp3_gnt_o    <= 1'b0;
            exp1_rd_vld_o <= 1'b0;
            exp3_rd_vld_o <= 1'b0;
            ram_rd_en_o   <= 1'b0;
            ram_rd_addr_o <= {ADDR_W{1'b0}};
            rd_data_o     <= {DATA_W{1'b0}};
            busy_o        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
`ifndef EXP_ARB_FIXED_PRIO_EN
            if (owner_req_s) begin
                last3_r <= (state_r == GNT3);
            end
`endif
            exp1_gnt_o  <= (state_nxt_s == GNT1);
            exp3_gnt_o  <= (state_nxt_s == GNT3);
            ram_rd_en_o <= owner_req_s;
            if (owner_req_s) begin
                ram_rd_addr_o <= owner_addr_s;
            end
            tag_r[0] <= owner_req_s ? owner_tag_s : TAG_NONE;
            for (int k = 1; k <= RAM_LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
            rd_data_o     <= ram_rd_data_i;
            exp1_rd_vld_o <= tag_r[RAM_LAT][0];
            exp3_rd_vld_o <= tag_r[RAM_LAT][1];
            busy_o        <= (state_nxt_s != IDLE) || inflight_s;
        end
    end

endmodule

// File: tb/tb_exp_ker_rd_arbiter.sv
// Bench for exp_ker_rd_arbiter: two instances (RAM_LAT 1 and 3) share stimulus, each with its own RAM model and scoreboard.
`timescale 1ns/1ps
module tb_exp_ker_rd_arbiter;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 64;
    localparam int BURST_LEN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, exp1_req, exp3_req;
    logic [ADDR_W-1:0] exp1_addr, exp3_addr;
    logic              gnt1 [2];
    logic              gnt3 [2];
    logic              vld1 [2];
    logic              vld3 [2];
    logic              ram_en [2];
    logic              busy [2];
    logic [ADDR_W-1:0] ram_addr [2];
    logic [DATA_W-1:0] ram_data [2];
    logic [DATA_W-1:0] rd_data [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return {20'hC0DE0, a, (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DATA_W-1:0] pipe [LAT];
        always @(posedge clk) begin
            pipe[0] <= ram_en[g] ? data_of(ram_addr[g]) : 64'hBAD0_BAD0_BAD0_BAD0;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign ram_data[g] = pipe[LAT-1];

        exp_ker_rd_arbiter #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .RAM_LAT(LAT)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .start_i(start),
            .exp1_req_i(exp1_req), .exp1_addr_i(exp1_addr),
            .exp1_gnt_o(gnt1[g]), .exp1_rd_vld_o(vld1[g]),
            .exp3_req_i(exp3_req), .exp3_addr_i(exp3_addr),
            .exp3_gnt_o(gnt3[g]), .exp3_rd_vld_o(vld3[g]),
            .ram_rd_en_o(ram_en[g]), .ram_rd_addr_o(ram_addr[g]),
            .ram_rd_data_i(ram_data[g]), .rd_data_o(rd_data[g]), .busy_o(busy[g])
        );
    end

    typedef struct packed {
        logic [1:0]        tag;
        logic [DATA_W-1:0] data;
        logic [31:0]       cyc;
    } sb_t;
    sb_t q0[$];
    sb_t q1[$];

    int gnt_log[$];
    int en_log[$];
    int acc_log[$];

    // Pushes every accepted beat, pops and checks every valid strobe.
    task automatic sb_monitor();
        sb_t e;
        int  lat;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                lat = (g == 0) ? 1 : 3;
                if (!rst && !start && exp1_req && gnt1[g]) begin
                    e.tag = 2'b01; e.data = data_of(exp1_addr); e.cyc = 32'(cyc);
                    if (g == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (!rst && !start && exp3_req && gnt3[g]) begin
                    e.tag = 2'b10; e.data = data_of(exp3_addr); e.cyc = 32'(cyc);
                    if (g == 0) q0.push_back(e); else q1.push_back(e);
                end
                if (vld1[g] || vld3[g]) begin
                    n_checks++;
                    if (((g == 0) ? q0.size() : q1.size()) == 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected inst%0d: strobe exp3/exp1=%b%b with no read outstanding", g, vld3[g], vld1[g]);
                    end else begin
                        if (g == 0) e = q0.pop_front(); else e = q1.pop_front();
                        if ({vld3[g], vld1[g]} !== e.tag) begin
                            n_fail++;
                            $display("FAIL sb_owner inst%0d: got %b expected %b", g, {vld3[g], vld1[g]}, e.tag);
                        end
                        n_checks++;
                        if (rd_data[g] !== e.data) begin
                            n_fail++;
                            $display("FAIL sb_data inst%0d: got %h expected %h", g, rd_data[g], e.data);
                        end
                        n_checks++;
                        if (32'(cyc) !== e.cyc + 32'(2 + lat)) begin
                            n_fail++;
                            $display("FAIL sb_latency inst%0d: strobe at cycle %0d expected %0d", g, cyc, e.cyc + 32'(2 + lat));
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each requester issues its beats with rising addresses, then drops req.
    task automatic drive(input int n1, input int n3, input int max_cyc, output int a1, output int a3);
        a1 = 0; a3 = 0;
        gnt_log.delete(); en_log.delete(); acc_log.delete();
        for (int c = 0; c < max_cyc; c++) begin
            exp1_req  = (a1 < n1);
            exp1_addr = ADDR_W'(a1);
            exp3_req  = (a3 < n3);
            exp3_addr = ADDR_W'(12'h800 + a3);
            @(negedge clk);
            gnt_log.push_back(gnt1[0] ? 1 : (gnt3[0] ? 3 : 0));
            en_log.push_back(int'(ram_en[0]));
            if (exp1_req && gnt1[0]) begin a1++; acc_log.push_back(1); end
            if (exp3_req && gnt3[0]) begin a3++; acc_log.push_back(3); end
            tick();
            if (a1 >= n1 && a3 >= n3) break;
        end
        exp1_req = 1'b0;
        exp3_req = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (10) tick();
        @(negedge clk);
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: outstanding reads %0d/%0d expected 0/0", name, q0.size(), q1.size());
        end
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (busy[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_busy_idle inst%0d: got %b expected 0", name, g, busy[g]);
            end
        end
        tick();
    endtask

    task automatic check_all_zero(input string name);
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if ({gnt1[g], gnt3[g], vld1[g], vld3[g], ram_en[g], busy[g]} !== 6'b0) begin
                n_fail++;
                $display("FAIL %s_flags inst%0d: got %b expected 000000", name, g,
                         {gnt1[g], gnt3[g], vld1[g], vld3[g], ram_en[g], busy[g]});
            end
            n_checks++;
            if (ram_addr[g] !== {ADDR_W{1'b0}} || rd_data[g] !== {DATA_W{1'b0}}) begin
                n_fail++;
                $display("FAIL %s_buses inst%0d: addr %h data %h expected 0", name, g, ram_addr[g], rd_data[g]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        exp1_req = 1'b1; exp3_req = 1'b1;
        exp1_addr = 12'h0AA; exp3_addr = 12'h855;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0; exp1_req = 1'b0; exp3_req = 1'b0;
        tick();
        q0.delete(); q1.delete();
    endtask

    task automatic test_exp1_only();
        int a1, a3, bad;
        drive(10, 0, 30, a1, a3);
        n_checks++;
        if (a1 != 10 || gnt_log.size() != 11) begin
            n_fail++;
            $display("FAIL exp1_only_cycles: beats %0d in %0d cycles expected 10 in 11", a1, gnt_log.size());
        end
        n_checks++;
        if (gnt_log.size() < 1 || gnt_log[0] != 0) begin
            n_fail++;
            $display("FAIL exp1_grant_latency: first-cycle owner %0d expected 0", (gnt_log.size() > 0) ? gnt_log[0] : -1);
        end
        bad = 0;
        for (int i = 1; i < gnt_log.size(); i++) if (gnt_log[i] != 1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL exp1_gnt_continuous: %0d cycles without 1x1 grant expected 0", bad);
        end
        bad = 0;
        for (int i = 2; i < en_log.size(); i++) if (en_log[i] != 1) bad++;
        n_checks++;
        if (en_log.size() < 2 || en_log[1] != 0 || bad != 0) begin
            n_fail++;
            $display("FAIL exp1_issue: en gaps %0d expected 0 with en low in first grant cycle", bad);
        end
        check_drained("exp1_only");
    endtask

    task automatic test_tie();
        int a1, a3, bad, gaps, exp_o;
`ifdef EXP_ARB_FIXED_PRIO_EN
        localparam int EXP_CYC  = 34;
        localparam int EXP_GAPS = 1;
`else
        localparam int EXP_CYC  = 33;
        localparam int EXP_GAPS = 0;
`endif
        drive(16, 16, 80, a1, a3);
        n_checks++;
        if (a1 != 16 || a3 != 16 || gnt_log.size() != EXP_CYC) begin
            n_fail++;
            $display("FAIL tie_cycles: beats %0d/%0d in %0d cycles expected 16/16 in %0d", a1, a3, gnt_log.size(), EXP_CYC);
        end
        bad = 0;
        for (int k = 0; k < acc_log.size(); k++) begin
`ifdef EXP_ARB_FIXED_PRIO_EN
            exp_o = (k < 16) ? 3 : 1;
`else
            exp_o = (((k / BURST_LEN) % 2) == 0) ? 3 : 1;
`endif
            if (acc_log[k] != exp_o) bad++;
        end
        n_checks++;
        if (bad != 0 || acc_log.size() != 32) begin
            n_fail++;
            $display("FAIL tie_order: %0d misordered of %0d beats expected 0 of 32", bad, acc_log.size());
        end
        gaps = 0;
        for (int i = 2; i < en_log.size(); i++) if (en_log[i] != 1) gaps++;
        n_checks++;
        if (gaps != EXP_GAPS) begin
            n_fail++;
            $display("FAIL tie_throughput: %0d idle port cycles expected %0d", gaps, EXP_GAPS);
        end
        check_drained("tie");
    endtask

    task automatic test_early_release();
        int a1, a3, bad;
        int exp_g [8] = '{0, 3, 3, 3, 1, 1, 1, 1};
        drive(4, 2, 30, a1, a3);
        bad = 0;
        for (int i = 0; i < 8; i++) if (i >= gnt_log.size() || gnt_log[i] != exp_g[i]) bad++;
        n_checks++;
        if (bad != 0 || gnt_log.size() != 8) begin
            n_fail++;
            $display("FAIL early_release_grants: %0d wrong grant cycles, %0d cycles expected 0, 8", bad, gnt_log.size());
        end
        check_drained("early_release");
    endtask

    task automatic test_start();
        exp1_addr = 12'h456; exp3_addr = 12'h123;
        exp1_req = 1'b1; exp3_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (ram_en[g] !== 1'b1 || busy[g] !== 1'b1 || gnt3[g] !== 1'b1) begin
                n_fail++;
                $display("FAIL start_pre_issue inst%0d: en %b busy %b gnt3 %b expected 1 1 1", g, ram_en[g], busy[g], gnt3[g]);
            end
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk);
        check_all_zero("start");
        tick();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_checks++;
            if (gnt3[g] !== 1'b1 || gnt1[g] !== 1'b0) begin
                n_fail++;
                $display("FAIL start_tie inst%0d: gnt3/gnt1 %b%b expected 10", g, gnt3[g], gnt1[g]);
            end
        end
        tick();
        exp1_req = 1'b0; exp3_req = 1'b0;
        check_drained("start");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        exp1_req = 1'b0; exp3_req = 1'b0;
        exp1_addr = {ADDR_W{1'b0}}; exp3_addr = {ADDR_W{1'b0}};
        fork
            sb_monitor();
        join_none
        test_reset();
        test_exp1_only();
        test_tie();
        test_early_release();
        test_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
